// File: rtl/cnn_layer_pkg.sv
// Shared constants, FSM encoding and output-count helper for the conv3x3 layer stream control.
package cnn_layer_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int IMG_WIDTH   = 220;
    localparam int IMG_HEIGHT  = 220;
    localparam int CHANNEL_OUT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A valid-padding 3x3 window yields one vector per interior pixel.
    function automatic int out_vectors(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with free-slot count; read data is the head entry, valid whenever !empty.
// Push into a full FIFO succeeds only when a pop happens in the same cycle; clr empties it.
module sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   free
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign free    = CW'(DEPTH) - count;
    assign pop_dat = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/layer1_stream_ctrl.sv
// Frame sequencer for the conv3x3+BN+ReLU layer: issues pixels (1-cycle latency), buffers output vectors, serializes words.
// Input issue is throttled by buffer credit since the layer cannot stall; output honours m_ready per word.
module layer1_stream_ctrl #(
    parameter int DATA_WIDTH  = cnn_layer_pkg::DATA_WIDTH,
    parameter int IMG_WIDTH   = cnn_layer_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT  = cnn_layer_pkg::IMG_HEIGHT,
    parameter int CHANNEL_OUT = cnn_layer_pkg::CHANNEL_OUT,
    parameter int FIFO_DEPTH  = 16,
    parameter int PIPE_SLACK  = 4,
    parameter int DRAIN_LIMIT = 4096
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              err_overflow,
    output logic                              err_timeout,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [DATA_WIDTH-1:0]             conv_data_in,
    output logic                              conv_valid_in,
    input  logic [DATA_WIDTH*CHANNEL_OUT-1:0] conv_data_out,
    input  logic                              conv_valid_out,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic [2:0]                        m_channel,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last
);
    import cnn_layer_pkg::*;

    localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int OUT_TOTAL = out_vectors(IMG_WIDTH, IMG_HEIGHT);
    localparam int ICW       = $clog2(PIX_TOTAL + 1);
    localparam int OCW       = $clog2(OUT_TOTAL + 1);
    localparam int FW        = $clog2(FIFO_DEPTH + 1);
    localparam int TW        = $clog2(DRAIN_LIMIT + 1);
    localparam int VW        = DATA_WIDTH * CHANNEL_OUT;

    state_t          state, state_nxt;
    logic [ICW-1:0]  in_cnt;
    logic [OCW-1:0]  out_cnt;
    logic [OCW-1:0]  pop_cnt;
    logic [TW-1:0]   drain_tmr;
    logic [2:0]      ch;
    logic [VW-1:0]   ser_vec;
    logic [VW-1:0]   fifo_dout;
    logic [FW-1:0]   fifo_free;
    logic            fifo_full, fifo_empty;
    logic            start_go, accept, last_pix, push, pop, drop, m_hs, timeout, drained;

    assign start_go = (state == ST_IDLE) && start;
    assign s_ready  = (state == ST_RUN) && (fifo_free > FW'(PIPE_SLACK));
    assign accept   = s_valid && s_ready;
    assign last_pix = accept && (in_cnt == ICW'(PIX_TOTAL - 1));
    assign m_hs     = m_valid && m_ready;
    assign pop      = !m_valid && !fifo_empty && !start_go;
    // A same-cycle pop makes room, so a full FIFO still takes the vector.
    assign push     = conv_valid_out && (!fifo_full || pop) && (out_cnt != OCW'(OUT_TOTAL));
    assign drop     = conv_valid_out && !push;
    assign timeout  = (state == ST_DRAIN) && (drain_tmr == TW'(DRAIN_LIMIT));
    assign drained  = (out_cnt == OCW'(OUT_TOTAL)) && fifo_empty && !m_valid;

    assign m_data    = ser_vec[int'(ch)*DATA_WIDTH +: DATA_WIDTH];
    assign m_channel = ch;
    assign m_last    = m_valid && (ch == 3'(CHANNEL_OUT - 1)) && (pop_cnt == OCW'(OUT_TOTAL));

    sync_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_vec_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_go),
        .push     (push),
        .push_dat (conv_data_out),
        .pop      (pop),
        .pop_dat  (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free     (fifo_free)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (last_pix) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drained || timeout) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_valid_in <= 1'b0;
            conv_data_in  <= '0;
            in_cnt        <= '0;
            out_cnt       <= '0;
            pop_cnt       <= '0;
            drain_tmr     <= '0;
            err_overflow  <= 1'b0;
            err_timeout   <= 1'b0;
            m_valid       <= 1'b0;
            ch            <= '0;
            ser_vec       <= '0;
        end else begin
            conv_valid_in <= accept;
            if (accept) conv_data_in <= s_data;

            if (state != ST_DRAIN || conv_valid_out || m_hs) drain_tmr <= '0;
            else if (!timeout)                               drain_tmr <= drain_tmr + TW'(1);

            if (start_go) begin
                in_cnt       <= '0;
                out_cnt      <= '0;
                pop_cnt      <= '0;
                err_overflow <= 1'b0;
                err_timeout  <= 1'b0;
                m_valid      <= 1'b0;
                ch           <= '0;
            end else begin
                if (accept)  in_cnt       <= in_cnt + ICW'(1);
                if (push)    out_cnt      <= out_cnt + OCW'(1);
                if (drop)    err_overflow <= 1'b1;
                if (timeout) err_timeout  <= 1'b1;
                if (pop) begin
                    ser_vec <= fifo_dout;
                    ch      <= '0;
                    m_valid <= 1'b1;
                    pop_cnt <= pop_cnt + OCW'(1);
                end else if (m_hs) begin
                    if (ch == 3'(CHANNEL_OUT - 1)) m_valid <= 1'b0;
                    else                           ch      <= ch + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer1_stream_ctrl.sv
// Directed bench: 5x5 frame through a latency-3 identity-kernel layer model; checks order, flags and FSM outcomes.
module tb_layer1_stream_ctrl;

    localparam int DW    = 32;
    localparam int CH    = 8;
    localparam int VW    = DW * CH;
    localparam int NPIX  = 25;
    localparam int NWORD = 72;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err_overflow, err_timeout;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] conv_data_in;
    logic          conv_valid_in;
    logic [VW-1:0] conv_data_out = '0;
    logic          conv_valid_out = 1'b0;
    logic [DW-1:0] m_data;
    logic [2:0]    m_channel;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int wcnt = 0;
    int mr_cyc = 0;
    int stalls;
    bit throttle = 1'b0;
    bit withhold = 1'b0;
    bit inject = 1'b0;

    // layer model state
    logic [VW-1:0] st_d [3];
    bit            st_v [3];
    logic [DW-1:0] img [NPIX];
    logic [VW-1:0] last_d, md;
    bit            mv, inject_pend;
    int            mp = 0;
    int            emitted = 0;

    layer1_stream_ctrl #(
        .DATA_WIDTH (DW), .IMG_WIDTH (5), .IMG_HEIGHT (5), .CHANNEL_OUT (CH),
        .FIFO_DEPTH (8), .PIPE_SLACK (4), .DRAIN_LIMIT (64)
    ) dut (
        .clk (clk), .rst (rst_n), .start (start), .busy (busy), .done (done),
        .err_overflow (err_overflow), .err_timeout (err_timeout),
        .s_data (s_data), .s_valid (s_valid), .s_ready (s_ready),
        .conv_data_in (conv_data_in), .conv_valid_in (conv_valid_in),
        .conv_data_out (conv_data_out), .conv_valid_out (conv_valid_out),
        .m_data (m_data), .m_channel (m_channel), .m_valid (m_valid),
        .m_ready (m_ready), .m_last (m_last)
    );

    always #5 clk = ~clk;

    // IEEE-754 single encoding of a small positive integer.
    function automatic logic [31:0] fbits(input int n);
        int e;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Latency-3 identity-kernel layer: channel k carries the window centre plus k.
    always @(negedge clk) begin
        if (!rst_n) begin
            st_v = '{default: 1'b0};
            conv_valid_out = 1'b0;
            conv_data_out = '0;
            mp = 0;
            emitted = 0;
            inject_pend = 1'b0;
        end else begin
            st_v[2] = st_v[1]; st_d[2] = st_d[1];
            st_v[1] = st_v[0]; st_d[1] = st_d[0];
            st_v[0] = 1'b0;
            if (conv_valid_in && mp < NPIX) begin
                img[mp] = conv_data_in;
                if (mp / 5 >= 2 && mp % 5 >= 2) begin
                    st_v[0] = 1'b1;
                    for (int k = 0; k < CH; k++) st_d[0][k*DW +: DW] = img[mp-6] + 32'(k);
                end
                mp++;
            end
            mv = st_v[2];
            md = st_d[2];
            if (mv) begin
                emitted++;
                last_d = md;
                if (withhold && emitted == 9) mv = 1'b0;
                if (inject && emitted == 9) inject_pend = 1'b1;
            end else if (inject_pend) begin
                mv = 1'b1;
                md = last_d;
                inject_pend = 1'b0;
            end
            conv_valid_out = mv;
            conv_data_out = md;
        end
    end

    always @(posedge clk) begin
        #1;
        mr_cyc++;
        m_ready = throttle ? (mr_cyc % 4 == 0) : 1'b1;
    end

    // Output monitor: word order, channel, data and m_last against the expected 5x5 result.
    always @(negedge clk) begin
        int v, k, c;
        if (rst_n) begin
            if (done) done_cnt++;
            if (m_valid && m_ready) begin
                v = wcnt / CH;
                k = wcnt % CH;
                c = (v / 3 + 1) * 5 + (v % 3 + 1) + 1;
                chk("m_channel", 32'(m_channel), 32'(k));
                chk("m_data", m_data, fbits(c) + 32'(k));
                chk("m_last", 32'(m_last), 32'(wcnt == NWORD - 1));
                wcnt++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_conv_valid_in"}, 32'(conv_valid_in), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_last"}, 32'(m_last), 0);
        chk({tag, "_err_overflow"}, 32'(err_overflow), 0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
        chk({tag, "_conv_data_in"}, conv_data_in, 0);
        chk({tag, "_m_data"}, m_data, 0);
    endtask

    task automatic run_frame(input int start_at, input int abort_at, output int n_stall);
        int guard;
        n_stall = 0;
        mp = 0; emitted = 0; inject_pend = 1'b0; wcnt = 0; done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int p = 0; p < NPIX; p++) begin
            s_valid = 1'b1;
            s_data = fbits(p + 1);
            start = (p == start_at);
            @(negedge clk);
            if (p == 0) begin
                chk("busy_after_start", 32'(busy), 1);
                chk("err_overflow_cleared", 32'(err_overflow), 0);
                chk("err_timeout_cleared", 32'(err_timeout), 0);
            end
            guard = 0;
            while (!s_ready && guard < 2000) begin
                n_stall++;
                guard++;
                @(negedge clk);
            end
            if (!s_ready) begin
                chk("pixel_accept_timeout", 0, 1);
                s_valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (p == abort_at) begin
                rst_n = 1'b0;
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int words, input bit ovf, input bit tmo);
        int guard;
        guard = 0;
        while (done_cnt == 0 && guard < 4000) begin
            guard++;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk({tag, "_done_once"}, 32'(done_cnt), 1);
        chk({tag, "_words"}, 32'(wcnt), 32'(words));
        chk({tag, "_err_overflow"}, 32'(err_overflow), 32'(ovf));
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(tmo));
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_s_ready"}, 32'(s_ready), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_frame(-1, -1, stalls);
        finish_frame("basic", NWORD, 1'b0, 1'b0);

        throttle = 1'b1;
        run_frame(-1, -1, stalls);
        finish_frame("throttle", NWORD, 1'b0, 1'b0);
        chk("throttle_s_ready_dropped", 32'(stalls > 0), 1);
        throttle = 1'b0;

        inject = 1'b1;
        run_frame(-1, -1, stalls);
        finish_frame("surplus", NWORD, 1'b1, 1'b0);
        inject = 1'b0;

        withhold = 1'b1;
        run_frame(-1, -1, stalls);
        finish_frame("timeout", NWORD - CH, 1'b0, 1'b1);
        withhold = 1'b0;

        run_frame(10, -1, stalls);
        finish_frame("start_ignored", NWORD, 1'b0, 1'b0);

        run_frame(-1, 11, stalls);
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 0);
        chk("abort_no_words", 32'(wcnt), 0);
        chk("abort_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
